// File: rtl/floating_point_mult_if.sv
// Operand/result bundle for the Q15.16 sign-magnitude multiplier.
// The master drives the operands; the slave (the multiplier) returns the product.
interface floating_point_mult_if;
  logic        in_valid;
  logic [14:0] A;
  logic [15:0] B;
  logic        signA;
  logic [14:0] C;
  logic [15:0] D;
  logic        signC;
  logic [31:0] out;
  logic        out_valid;
  logic        ovf;

  modport master (
    output in_valid, A, B, signA, C, D, signC,
    input  out, out_valid, ovf
  );

  modport slave (
    input  in_valid, A, B, signA, C, D, signC,
    output out, out_valid, ovf
  );
endinterface

// File: rtl/floating_point_mult.sv
// Two-stage Q15.16 x Q15.16 -> Q15.16 sign-magnitude multiplier with saturation.
// Stage 1 captures operands, stage 2 captures the truncated/saturated product.
module floating_point_mult (
  input  logic                   clk,
  input  logic                   rst_n,
  floating_point_mult_if.slave   bus
);

  logic [30:0] s1_ma_q, s1_ma_d;
  logic [30:0] s1_mc_q, s1_mc_d;
  logic        s1_sign_q, s1_sign_d;
  logic        s1_valid_q, s1_valid_d;

  logic [31:0] out_q, out_d;
  logic        ovf_q, ovf_d;
  logic        out_valid_q, out_valid_d;

  logic [61:0] prod;
  logic [45:0] scaled;
  logic        sat;
  logic [30:0] mag;
  logic        neg;

  // Operands are only captured on valid cycles so idle inputs never toggle the multiplier.
  always_comb begin
    s1_valid_d = bus.in_valid;
    s1_ma_d    = s1_ma_q;
    s1_mc_d    = s1_mc_q;
    s1_sign_d  = s1_sign_q;
    if (bus.in_valid) begin
      s1_ma_d   = {bus.A, bus.B};
      s1_mc_d   = {bus.C, bus.D};
      s1_sign_d = bus.signA ^ bus.signC;
    end
  end

  // Q30.32 product; dropping 16 LSBs truncates toward zero and leaves Q30.16.
  assign prod   = 62'(s1_ma_q) * 62'(s1_mc_q);
  assign scaled = 46'(prod >> 16);
  assign sat    = |scaled[45:31];
  assign mag    = sat ? 31'h7FFF_FFFF : scaled[30:0];
  assign neg    = s1_sign_q & (mag != 31'd0);

  always_comb begin
    out_valid_d = s1_valid_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    if (s1_valid_q) begin
      out_d = {neg, mag};
      ovf_d = sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ma_q     <= '0;
      s1_mc_q     <= '0;
      s1_sign_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_ma_q     <= s1_ma_d;
      s1_mc_q     <= s1_mc_d;
      s1_sign_q   <= s1_sign_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_floating_point_mult.sv
// Directed and randomized check of floating_point_mult against a real-number-style
// reference: product of two Q15.16 magnitudes, truncated, saturated, signed.
module tb_floating_point_mult;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  floating_point_mult_if bus_if ();

  floating_point_mult dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pipeline state: what stage 1 holds, what the output shows.
  logic        m1_v;
  logic [31:0] m1_out;
  logic        m1_ovf;
  string       m1_tag;
  logic        m2_v;
  logic [31:0] m2_out;
  logic        m2_ovf;
  string       m2_tag;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value-level model: integer product of the scaled magnitudes, divided by 2^16.
  function automatic logic [32:0] ref_mult(input logic [14:0] a, input logic [15:0] b, input logic sa,
                                           input logic [14:0] c, input logic [15:0] d, input logic sc);
    longint unsigned ma, mc, p, q;
    logic [31:0] mag;
    logic        ov, neg;
    ma = longint'(a) * 65536 + longint'(b);
    mc = longint'(c) * 65536 + longint'(d);
    p  = ma * mc;
    q  = p / 65536;
    if (q > 64'h7FFF_FFFF) begin
      mag = 32'h7FFF_FFFF;
      ov  = 1'b1;
    end else begin
      mag = 32'(q);
      ov  = 1'b0;
    end
    neg = (sa != sc) && (mag != 0);
    return {ov, (neg ? 32'h8000_0000 : 32'h0) | mag};
  endfunction

  task automatic tick(input logic v, input logic [14:0] a, input logic [15:0] b, input logic sa,
                      input logic [14:0] c, input logic [15:0] d, input logic sc, input string tag);
    logic [32:0] e;
    bus_if.in_valid = v;
    bus_if.A = a; bus_if.B = b; bus_if.signA = sa;
    bus_if.C = c; bus_if.D = d; bus_if.signC = sc;
    e = ref_mult(a, b, sa, c, d, sc);
    @(posedge clk);
    #1;
    m2_v = m1_v;
    if (m1_v) begin
      m2_out = m1_out;
      m2_ovf = m1_ovf;
      m2_tag = m1_tag;
    end
    m1_v = v;
    if (v) begin
      m1_out = e[31:0];
      m1_ovf = e[32];
      m1_tag = tag;
    end
    check_value({m2_tag, "_vld"}, 64'(bus_if.out_valid), 64'(m2_v));
    check_value({m2_tag, "_out"}, 64'(bus_if.out), 64'(m2_out));
    check_value({m2_tag, "_ovf"}, 64'(bus_if.ovf), 64'(m2_ovf));
    if (m2_v)
      $display("txn %s: out=%08h ovf=%0b", m2_tag, bus_if.out, bus_if.ovf);
  endtask

  task automatic idle();
    tick(1'b0, 15'($urandom), 16'($urandom), 1'($urandom), 15'($urandom), 16'($urandom), 1'($urandom), "idle");
  endtask

  task automatic model_reset();
    m1_v = 1'b0; m1_out = '0; m1_ovf = 1'b0; m1_tag = "rst";
    m2_v = 1'b0; m2_out = '0; m2_ovf = 1'b0; m2_tag = "rst";
  endtask

  function automatic logic [14:0] pick_int(input int mode);
    case (mode)
      0: return 15'($urandom);
      1: return 15'($urandom_range(0, 255));
      2: return 15'd0;
      default: return 15'($urandom_range(150, 210));
    endcase
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    model_reset();
    bus_if.in_valid = 1'b0;
    bus_if.A = '0; bus_if.B = '0; bus_if.signA = 1'b0;
    bus_if.C = '0; bus_if.D = '0; bus_if.signC = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("reset_out", 64'(bus_if.out), 64'h0);
    check_value("reset_ovf", 64'(bus_if.ovf), 64'h0);
    check_value("reset_vld", 64'(bus_if.out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.5 x 3.25 with exact two-cycle latency
    tick(1, 15'd1, 16'h8000, 0, 15'd3, 16'h4000, 0, "p1");
    check_value("p1_early_vld", 64'(bus_if.out_valid), 64'h0);
    idle();
    check_value("tp_1p5x3p25", 64'(bus_if.out), 64'h0004_E000);
    idle();

    // Sign combinations back-to-back
    tick(1, 15'd1, 16'h8000, 0, 15'd3, 16'h4000, 1, "s01");
    tick(1, 15'd1, 16'h8000, 1, 15'd3, 16'h4000, 0, "s10");
    check_value("tp_s01", 64'(bus_if.out), 64'h8004_E000);
    tick(1, 15'd1, 16'h8000, 1, 15'd3, 16'h4000, 1, "s11");
    check_value("tp_s10", 64'(bus_if.out), 64'h8004_E000);
    idle();
    check_value("tp_s11", 64'(bus_if.out), 64'h0004_E000);

    // 100.5 x 100.25, overflow both signs, negative-zero suppression
    tick(1, 15'd100, 16'h8000, 0, 15'd100, 16'h4000, 0, "big");
    tick(1, 15'd200, 16'h0000, 0, 15'd200, 16'h0000, 0, "ovfp");
    check_value("tp_big", 64'(bus_if.out), 64'h275B_2000);
    tick(1, 15'd200, 16'h0000, 1, 15'd200, 16'h0000, 0, "ovfn");
    check_value("tp_ovfp", 64'({bus_if.ovf, bus_if.out}), 64'h1_7FFF_FFFF);
    tick(1, 15'd0, 16'h0001, 1, 15'd0, 16'h0001, 0, "tiny");
    check_value("tp_ovfn", 64'({bus_if.ovf, bus_if.out}), 64'h1_FFFF_FFFF);
    idle();
    check_value("tp_tiny", 64'({bus_if.ovf, bus_if.out}), 64'h0_0000_0000);
    idle();

    // Asynchronous reset with two operations in flight
    tick(1, 15'd7, 16'h1234, 1, 15'd9, 16'h8000, 0, "fl1");
    tick(1, 15'd5, 16'h0000, 0, 15'd6, 16'h0000, 0, "fl2");
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_rst_out", 64'(bus_if.out), 64'h0);
    check_value("async_rst_ovf", 64'(bus_if.ovf), 64'h0);
    check_value("async_rst_vld", 64'(bus_if.out_valid), 64'h0);
    model_reset();
    bus_if.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    tick(1, 15'd2, 16'h0000, 0, 15'd3, 16'h0000, 1, "post");
    idle();
    check_value("tp_post_rst", 64'(bus_if.out), 64'h8006_0000);
    idle();

    // Randomized traffic with mixed magnitude ranges
    for (int i = 0; i < 400; i++) begin
      int ma_mode, mc_mode;
      ma_mode = int'($urandom_range(0, 3));
      mc_mode = int'($urandom_range(0, 3));
      tick(($urandom_range(0, 3) != 0),
           pick_int(ma_mode), 16'($urandom), 1'($urandom),
           pick_int(mc_mode), 16'($urandom), 1'($urandom),
           $sformatf("r%0d", i));
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
